// File: rtl/amba_mem_arbiter.sv
// amba_mem_arbiter: two-port (instruction fetch / data) front end onto a single
// AXI4-lite master. One transaction is in flight at a time; each walks through
// IDLE -> ADDR -> RESP -> DONE and finishes with a one-cycle done pulse on the
// requesting port.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests. When it is left undefined, port 1 (data) always wins.
module amba_mem_arbiter #(
  parameter logic [2:0] PROT = 3'b010
) (
  input  logic        ACLK,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] AWADDR,
  output logic [2:0]  AWPROT,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic        BVALID,
  input  logic [1:0]  BRESP,
  output logic        BREADY,
  output logic [31:0] ARADDR,
  output logic [2:0]  ARPROT,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic        RVALID,
  input  logic [1:0]  RRESP,
  input  logic [31:0] RDATA,
  output logic        RREADY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        win_q, win_d;      // 0 = port 0, 1 = port 1
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic        grant1;
  logic        resp_done;
  logic        resp_err;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_q;            // port granted by the most recent transaction

  // Fairness: on a tie, grant whichever port was not served last.
  always_comb grant1 = req1 && (!req0 || !last_q);

  // Remember the winner once its transaction has completed.
  always_ff @(posedge ACLK) begin
    if (reset)                 last_q <= 1'b0;
    else if (state_q == DONE)  last_q <= win_q;
  end
`else
  // Fixed priority: the data port always wins; instruction fetch may starve.
  always_comb grant1 = req1;
`endif

  // Next-state and datapath update for the whole transaction sequence.
  always_comb begin
    // NOTE: every _d starts from its _q (or pulse default) so that no path through the case leaves a variable unassigned, which would infer a latch.
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    resp_done = 1'b0;
    resp_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d   = ADDR;
          win_d     = grant1;
          we_d      = grant1 ? we1    : we0;
          addr_d    = grant1 ? addr1  : addr0;
          wdata_d   = grant1 ? wdata1 : wdata0;
          awvalid_d = we_d;
          wvalid_d  = we_d;
          bready_d  = we_d;
          arvalid_d = !we_d;
          rready_d  = !we_d;
        end
      end
      ADDR: begin
        if (we_q) begin
          // AW and W handshake independently; move on once both have been taken.
          if (AWREADY) awvalid_d = 1'b0;
          if (WREADY)  wvalid_d  = 1'b0;
          if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) state_d = RESP;
        end else if (ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (we_q) begin
          if (BVALID) begin
            bready_d  = 1'b0;
            resp_done = 1'b1;
            resp_err  = (BRESP != 2'b00);
          end
        end else if (RVALID) begin
          rready_d  = 1'b0;
          resp_done = 1'b1;
          resp_err  = (RRESP != 2'b00);
          // Read data is returned even for an error response.
          if (win_q) rdata1_d = RDATA;
          else       rdata0_d = RDATA;
        end
        if (resp_done) begin
          state_d = DONE;
          done0_d = !win_q;
          done1_d = win_q;
          err0_d  = !win_q && resp_err;
          err1_d  = win_q && resp_err;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values, whatever the statement order.
    if (reset) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  // Address and data only change in IDLE, so they stay stable under back-pressure.
  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;
  assign WDATA   = wdata_q;
  assign AWPROT  = PROT;
  assign ARPROT  = PROT;
  assign WSTRB   = 4'b1111;
  assign AWVALID = awvalid_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_amba_mem_arbiter.sv
// Directed testbench for amba_mem_arbiter. The bench plays the AXI-lite slave
// by hand. Inputs are driven on the falling edge, and outputs are sampled on
// the falling edge before new inputs are driven.
module tb_amba_mem_arbiter;

  logic        ACLK = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 ACLK = ~ACLK;

  amba_mem_arbiter #(.PROT(3'b010)) dut (
    .ACLK(ACLK), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RRESP(RRESP), .RDATA(RDATA), .RREADY(RREADY)
  );

  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic slave_idle();
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
    ARREADY = 0; RVALID = 0; RRESP = 2'b00; RDATA = '0;
  endtask

  // Advance until the given port's done is seen or the budget runs out.
  task automatic wait_done(input int port, input int max_cycles,
                           output int cycles, output bit seen);
    cycles = 0;
    seen   = 0;
    while (!seen && cycles < max_cycles) begin
      step();
      cycles++;
      seen = (port == 0) ? (done0 === 1'b1) : (done1 === 1'b1);
    end
  endtask

  task automatic test_reset();
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    slave_idle();
    step();
    step();
    tests_run++;
    if ({done0, done1, err0, err1} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_done_err: got %b want 0000", {done0, done1, err0, err1});
    end
    tests_run++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_valid_ready: got %b want 00000", {AWVALID, WVALID, BREADY, ARVALID, RREADY});
    end
    tests_run++;
    if ({rdata0, rdata1, AWADDR, ARADDR, WDATA} !== 160'b0) begin
      tests_failed++; $display("FAIL reset_data: rdata0=%h rdata1=%h awaddr=%h araddr=%h wdata=%h want all 0", rdata0, rdata1, AWADDR, ARADDR, WDATA);
    end
    reset = 0;
    step();
  endtask

  task automatic test_single_read();
    int  cyc;
    bit  seen;
    req0 = 1; we0 = 0; addr0 = 32'h0000_0100;
    ARREADY = 1; RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00;
    step();
    tests_run++;
    if ({ARVALID, RREADY} !== 2'b11 || ARADDR !== 32'h100 || ARPROT !== 3'b010) begin
      tests_failed++; $display("FAIL rd_addr_phase: arvalid=%b rready=%b araddr=%h arprot=%b want 1 1 00000100 010", ARVALID, RREADY, ARADDR, ARPROT);
    end
    wait_done(0, 8, cyc, seen);
    // Cycle of req sampling counts as 1: IDLE, ADDR, RESP, then done in cycle 4.
    tests_run++;
    if (!seen || (cyc + 2) != 4) begin
      tests_failed++; $display("FAIL rd_latency: seen=%0d cycles=%0d want seen=1 cycles=4", seen, cyc + 2);
    end
    tests_run++;
    if (rdata0 !== 32'hDEAD_BEEF || err0 !== 1'b0 || done1 !== 1'b0) begin
      tests_failed++; $display("FAIL rd_result: rdata0=%h err0=%b done1=%b want deadbeef 0 0", rdata0, err0, done1);
    end
    req0 = 0;
    slave_idle();
    step();
    tests_run++;
    if (done0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL rd_pulse_hold: done0=%b rdata0=%h want 0 deadbeef", done0, rdata0);
    end
  endtask

  task automatic test_split_write();
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h55AA;
    slave_idle();
    step();
    tests_run++;
    if ({AWVALID, WVALID, BREADY} !== 3'b111 || AWADDR !== 32'h20 || WDATA !== 32'h55AA || WSTRB !== 4'hF || AWPROT !== 3'b010) begin
      tests_failed++; $display("FAIL wr_start: aw=%b w=%b b=%b awaddr=%h wdata=%h wstrb=%h awprot=%b want 1 1 1 20 55aa f 010", AWVALID, WVALID, BREADY, AWADDR, WDATA, WSTRB, AWPROT);
    end
    AWREADY = 1;
    step();
    tests_run++;
    if ({AWVALID, WVALID, BREADY} !== 3'b011 || WDATA !== 32'h55AA) begin
      tests_failed++; $display("FAIL wr_aw_first: aw=%b w=%b b=%b wdata=%h want 0 1 1 55aa", AWVALID, WVALID, BREADY, WDATA);
    end
    AWREADY = 0; WREADY = 1;
    step();
    tests_run++;
    if ({AWVALID, WVALID, BREADY, done1} !== 4'b0010) begin
      tests_failed++; $display("FAIL wr_resp_wait: aw=%b w=%b b=%b done1=%b want 0 0 1 0", AWVALID, WVALID, BREADY, done1);
    end
    WREADY = 0; BVALID = 1; BRESP = 2'b10;
    step();
    tests_run++;
    if ({done1, err1, done0, BREADY} !== 4'b1100) begin
      tests_failed++; $display("FAIL wr_done_err: done1=%b err1=%b done0=%b bready=%b want 1 1 0 0", done1, err1, done0, BREADY);
    end
    req1 = 0;
    slave_idle();
    step();
    tests_run++;
    if ({done1, err1} !== 2'b00) begin
      tests_failed++; $display("FAIL wr_pulse: done1=%b err1=%b want 0 0", done1, err1);
    end
  endtask

  task automatic test_simultaneous();
    int exp_win [4];
    int got;
    int cyc;
    bit seen;
`ifdef ARB_ROUND_ROBIN_EN
    exp_win = '{1, 0, 1, 0};
`else
    exp_win = '{1, 1, 1, 1};
`endif
    reset = 1;
    step();
    reset = 0;
    ARREADY = 1; RVALID = 1; RDATA = 32'hCAFE_0001; RRESP = 2'b00;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h40; addr1 = 32'h44;
    for (int i = 0; i < 4; i++) begin
      got = -1;
      cyc = 0;
      while (got < 0 && cyc < 10) begin
        step();
        cyc++;
        if (done1 === 1'b1)      got = 1;
        else if (done0 === 1'b1) got = 0;
      end
      tests_run++;
      if (got != exp_win[i]) begin
        tests_failed++; $display("FAIL sim_grant%0d: got port %0d want port %0d", i, got, exp_win[i]);
      end
      if (i == 3) begin
`ifdef ARB_ROUND_ROBIN_EN
        req0 = 0;
        req1 = 0;
`else
        req1 = 0;
`endif
      end
    end
    tests_run++;
    if (rdata1 !== 32'hCAFE_0001) begin
      tests_failed++; $display("FAIL sim_rdata1: got %h want cafe0001", rdata1);
    end
`ifndef ARB_ROUND_ROBIN_EN
    wait_done(0, 10, cyc, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL sim_port0_after: done0 seen=%0d want 1", seen);
    end
    req0 = 0;
`endif
    slave_idle();
    step();
  endtask

  task automatic test_backpressure();
    int ndone = 0;
    int cyc;
    bit seen;
    req0 = 1; we0 = 0; addr0 = 32'h300;
    slave_idle();
    step();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (ARVALID !== 1'b1 || ARADDR !== 32'h300) begin
        tests_failed++; $display("FAIL bp_stable%0d: arvalid=%b araddr=%h want 1 00000300", i, ARVALID, ARADDR);
      end
      if (done0 === 1'b1) ndone++;
      step();
    end
    ARREADY = 1;
    step();
    ARREADY = 0; RVALID = 1; RDATA = 32'h1234_5678; RRESP = 2'b10;
    wait_done(0, 6, cyc, seen);
    if (seen) ndone++;
    tests_run++;
    if (!seen || rdata0 !== 32'h1234_5678 || err0 !== 1'b1 || rdata1 !== 32'hCAFE_0001) begin
      tests_failed++; $display("FAIL bp_result: seen=%0d rdata0=%h err0=%b rdata1=%h want 1 12345678 1 cafe0001", seen, rdata0, err0, rdata1);
    end
    req0 = 0;
    slave_idle();
    for (int i = 0; i < 3; i++) begin
      step();
      if (done0 === 1'b1) ndone++;
    end
    tests_run++;
    if (ndone != 1) begin
      tests_failed++; $display("FAIL bp_single_done: got %0d done pulses want 1", ndone);
    end
  endtask

  task automatic test_reset_in_resp();
    int cyc;
    bit seen;
    req0 = 1; we0 = 0; addr0 = 32'h500;
    slave_idle();
    ARREADY = 1;
    step();
    step();
    tests_run++;
    if ({ARVALID, RREADY} !== 2'b01) begin
      tests_failed++; $display("FAIL rst_in_resp_pre: arvalid=%b rready=%b want 0 1", ARVALID, RREADY);
    end
    reset = 1;
    step();
    tests_run++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, done0, done1} !== 7'b0) begin
      tests_failed++; $display("FAIL rst_in_resp_clear: got %b want 0000000", {AWVALID, WVALID, BREADY, ARVALID, RREADY, done0, done1});
    end
    reset = 0;
    RVALID = 1; RDATA = 32'hA5A5_A5A5;
    wait_done(0, 8, cyc, seen);
    tests_run++;
    if (!seen || cyc != 3 || rdata0 !== 32'hA5A5_A5A5 || err0 !== 1'b0) begin
      tests_failed++; $display("FAIL rst_recover: seen=%0d edges=%0d rdata0=%h err0=%b want 1 3 a5a5a5a5 0", seen, cyc, rdata0, err0);
    end
    req0 = 0;
    slave_idle();
    step();
  endtask

  initial begin
    reset = 1;
    @(negedge ACLK);
    test_reset();
    test_single_read();
    test_split_write();
    test_simultaneous();
    test_backpressure();
    test_reset_in_resp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
